// File: rtl/disp_src_sched.sv
// Display source scheduler: manual/auto-rotating selection of eight 32-bit
// debug sources, with CPU writes pre-empting auto rotation for a hold period.
module disp_src_sched #(
  parameter logic [31:0] DWELL    = 32'd25000000,
  parameter logic [31:0] CPU_HOLD = 32'd50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  Test,
  input  logic        auto_en,
  input  logic        cpu_req,
  input  logic [31:0] cpu_data,
  input  logic [31:0] src_data1,
  input  logic [31:0] src_data2,
  input  logic [31:0] src_data3,
  input  logic [31:0] src_data4,
  input  logic [31:0] src_data5,
  input  logic [31:0] src_data6,
  input  logic [31:0] src_data7,
  output logic [31:0] disp_num,
  output logic [2:0]  disp_sel,
  output logic        cpu_ack,
  output logic        in_hold
);

  localparam logic [31:0] RST_WORD = 32'hAA5555AA;

  typedef enum logic [1:0] {MANUAL, AUTO, CPU_PRE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d, saved_q, saved_d, sel_q, sel_d;
  logic [31:0] dwell_q, dwell_d, hold_q, hold_d;
  logic [31:0] latch_q, latch_d, disp_q, disp_d;
  logic        ack_q, hold_flag_q;
  logic [7:0][31:0] srcs;

  always_comb begin
    latch_d = cpu_req ? cpu_data : latch_q;
    // Index 0 uses the post-write latch so a same-cycle CPU write shows at once
    srcs[0] = latch_d;
    srcs[1] = {2'b00, src_data1[31:2]};
    srcs[2] = src_data2;
    srcs[3] = src_data3;
    srcs[4] = src_data4;
    srcs[5] = src_data5;
    srcs[6] = src_data6;
    srcs[7] = src_data7;

    state_d = state_q;
    idx_d   = idx_q;
    saved_d = saved_q;
    dwell_d = dwell_q;
    hold_d  = hold_q;
    sel_d   = 3'd0;

    case (state_q)
      MANUAL: begin
        sel_d = Test;
        if (auto_en && cpu_req) begin
          state_d = CPU_PRE;
          saved_d = Test;
          hold_d  = CPU_HOLD - 32'd1;
          sel_d   = 3'd0;
        end else if (auto_en) begin
          state_d = AUTO;
          idx_d   = Test;
          dwell_d = DWELL - 32'd1;
        end
      end
      AUTO: begin
        if (!auto_en) begin
          state_d = MANUAL;
          sel_d   = Test;
        end else if (cpu_req) begin
          state_d = CPU_PRE;
          saved_d = idx_q;
          hold_d  = CPU_HOLD - 32'd1;
        end else begin
          if (dwell_q == 32'd0) begin
            idx_d   = idx_q + 3'd1;
            dwell_d = DWELL - 32'd1;
          end else begin
            dwell_d = dwell_q - 32'd1;
          end
          sel_d = idx_d;
        end
      end
      CPU_PRE: begin
        if (!auto_en) begin
          state_d = MANUAL;
          sel_d   = Test;
        end else if (cpu_req) begin
          hold_d = CPU_HOLD - 32'd1;
        end else if (hold_q == 32'd0) begin
          // Rotation resumes where it was, with a fresh dwell period
          state_d = AUTO;
          idx_d   = saved_q;
          dwell_d = DWELL - 32'd1;
          sel_d   = saved_q;
        end else begin
          hold_d = hold_q - 32'd1;
        end
      end
      default: begin
        state_d = MANUAL;
        sel_d   = Test;
      end
    endcase

    disp_d = srcs[sel_d];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= MANUAL;
      idx_q       <= 3'd0;
      saved_q     <= 3'd0;
      sel_q       <= 3'd0;
      dwell_q     <= 32'd0;
      hold_q      <= 32'd0;
      latch_q     <= RST_WORD;
      disp_q      <= RST_WORD;
      ack_q       <= 1'b0;
      hold_flag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      saved_q     <= saved_d;
      sel_q       <= sel_d;
      dwell_q     <= dwell_d;
      hold_q      <= hold_d;
      latch_q     <= latch_d;
      disp_q      <= disp_d;
      ack_q       <= cpu_req;
      hold_flag_q <= (state_d == CPU_PRE);
    end
  end

  assign disp_num = disp_q;
  assign disp_sel = sel_q;
  assign cpu_ack  = ack_q;
  assign in_hold  = hold_flag_q;

endmodule

// File: tb/tb_disp_src_sched.sv
// Directed bench for disp_src_sched: main instance with DWELL=4/CPU_HOLD=3,
// plus a DWELL=1/CPU_HOLD=1 instance for the minimum-period corner.
module tb_disp_src_sched;

  logic        clk = 1'b0;
  logic        rst, auto_en, cpu_req;
  logic [2:0]  Test;
  logic [31:0] cpu_data;
  logic [31:0] s1, s2, s3, s4, s5, s6, s7;
  logic [31:0] disp_num, f_disp_num;
  logic [2:0]  disp_sel, f_disp_sel;
  logic        cpu_ack, in_hold, f_cpu_ack, f_in_hold;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  disp_src_sched #(.DWELL(32'd4), .CPU_HOLD(32'd3)) u_dut (
    .clk(clk), .rst(rst), .Test(Test), .auto_en(auto_en), .cpu_req(cpu_req),
    .cpu_data(cpu_data), .src_data1(s1), .src_data2(s2), .src_data3(s3),
    .src_data4(s4), .src_data5(s5), .src_data6(s6), .src_data7(s7),
    .disp_num(disp_num), .disp_sel(disp_sel), .cpu_ack(cpu_ack), .in_hold(in_hold)
  );

  disp_src_sched #(.DWELL(32'd1), .CPU_HOLD(32'd1)) u_fast (
    .clk(clk), .rst(rst), .Test(Test), .auto_en(auto_en), .cpu_req(cpu_req),
    .cpu_data(cpu_data), .src_data1(s1), .src_data2(s2), .src_data3(s3),
    .src_data4(s4), .src_data5(s5), .src_data6(s6), .src_data7(s7),
    .disp_num(f_disp_num), .disp_sel(f_disp_sel), .cpu_ack(f_cpu_ack), .in_hold(f_in_hold)
  );

  // Hand-derived source words for the fixed stimulus values below
  function automatic logic [31:0] exp_src(input logic [2:0] i, input logic [31:0] latch);
    case (i)
      3'd0:    return latch;
      3'd1:    return 32'h00100004;
      3'd2:    return 32'h22222222;
      3'd3:    return 32'h33333333;
      3'd4:    return 32'h44444444;
      3'd5:    return 32'h55555555;
      3'd6:    return 32'h66666666;
      default: return 32'h77777777;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; cpu_req = 1'b0; auto_en = 1'b0; Test = 3'd0; cpu_data = 32'h0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cpu_req = 1'b0; auto_en = 1'b0; Test = 3'd0;
    tick();
    checks++; if (disp_num !== 32'hAA5555AA) begin errors++; $display("FAIL reset_disp got %h want aa5555aa", disp_num); end
    checks++; if (disp_sel !== 3'd0) begin errors++; $display("FAIL reset_sel got %0d want 0", disp_sel); end
    checks++; if (cpu_ack !== 1'b0 || in_hold !== 1'b0) begin errors++; $display("FAIL reset_flags got ack=%b hold=%b want 0 0", cpu_ack, in_hold); end
    rst = 1'b0;
    tick();
    checks++; if (disp_num !== 32'hAA5555AA || disp_sel !== 3'd0) begin errors++; $display("FAIL idle_after_reset got %h/%0d want aa5555aa/0", disp_num, disp_sel); end
  endtask

  task automatic test_manual();
    do_reset();
    Test = 3'd1;
    tick();
    checks++; if (disp_num !== 32'h00100004 || disp_sel !== 3'd1) begin errors++; $display("FAIL manual_pc got %h/%0d want 00100004/1", disp_num, disp_sel); end
    Test = 3'd7;
    tick();
    checks++; if (disp_num !== 32'h77777777 || disp_sel !== 3'd7) begin errors++; $display("FAIL manual_src7 got %h/%0d want 77777777/7", disp_num, disp_sel); end
    Test = 3'd0; cpu_req = 1'b1; cpu_data = 32'h12345678;
    tick();
    checks++; if (disp_num !== 32'h12345678) begin errors++; $display("FAIL manual_cpu_same_edge got %h want 12345678", disp_num); end
    checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL manual_ack got %b want 1", cpu_ack); end
    cpu_req = 1'b0; cpu_data = 32'h0;
    tick();
    checks++; if (cpu_ack !== 1'b0 || disp_num !== 32'h12345678) begin errors++; $display("FAIL manual_ack_drop got ack=%b disp=%h want 0/12345678", cpu_ack, disp_num); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d [3] = '{32'hA0000001, 32'hB0000002, 32'hC0000003};
    do_reset();
    Test = 3'd0;
    for (int i = 0; i < 3; i++) begin
      cpu_req = 1'b1; cpu_data = d[i];
      tick();
      checks++; if (cpu_ack !== 1'b1 || disp_num !== d[i]) begin errors++; $display("FAIL b2b_%0d got ack=%b disp=%h want 1/%h", i, cpu_ack, disp_num, d[i]); end
    end
    cpu_req = 1'b0; cpu_data = 32'h0;
    tick();
    checks++; if (cpu_ack !== 1'b0 || disp_num !== 32'hC0000003) begin errors++; $display("FAIL b2b_last got ack=%b disp=%h want 0/c0000003", cpu_ack, disp_num); end
  endtask

  task automatic test_auto_rotate();
    logic [2:0] seq [13] = '{3'd6, 3'd6, 3'd6, 3'd6, 3'd7, 3'd7, 3'd7, 3'd7,
                             3'd0, 3'd0, 3'd0, 3'd0, 3'd1};
    do_reset();
    Test = 3'd6; auto_en = 1'b1;
    for (int i = 0; i < 13; i++) begin
      tick();
      checks++;
      if (disp_sel !== seq[i] || disp_num !== exp_src(seq[i], 32'hAA5555AA)) begin
        errors++; $display("FAIL auto_rotate_%0d got %0d/%h want %0d/%h", i, disp_sel, disp_num, seq[i], exp_src(seq[i], 32'hAA5555AA));
      end
    end
    auto_en = 1'b0; Test = 3'd2;
    tick();
    checks++; if (disp_sel !== 3'd2 || in_hold !== 1'b0) begin errors++; $display("FAIL auto_exit got sel=%0d hold=%b want 2/0", disp_sel, in_hold); end
  endtask

  task automatic test_cpu_preempt();
    do_reset();
    Test = 3'd3; auto_en = 1'b1;
    tick();
    cpu_req = 1'b1; cpu_data = 32'hDEADBEEF;
    tick();
    checks++; if (disp_sel !== 3'd0 || in_hold !== 1'b1 || disp_num !== 32'hDEADBEEF || cpu_ack !== 1'b1) begin
      errors++; $display("FAIL preempt_enter got sel=%0d hold=%b disp=%h ack=%b want 0/1/deadbeef/1", disp_sel, in_hold, disp_num, cpu_ack); end
    cpu_req = 1'b0; cpu_data = 32'h0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (disp_sel !== 3'd0 || in_hold !== 1'b1 || disp_num !== 32'hDEADBEEF) begin
        errors++; $display("FAIL preempt_hold_%0d got sel=%0d hold=%b disp=%h want 0/1/deadbeef", i, disp_sel, in_hold, disp_num); end
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (disp_sel !== 3'd3 || in_hold !== 1'b0 || disp_num !== 32'h33333333) begin
        errors++; $display("FAIL preempt_resume_%0d got sel=%0d hold=%b disp=%h want 3/0/33333333", i, disp_sel, in_hold, disp_num); end
    end
    tick();
    checks++; if (disp_sel !== 3'd4) begin errors++; $display("FAIL preempt_next got %0d want 4", disp_sel); end
  endtask

  task automatic test_hold_restart();
    logic [4:0] pat = 5'b00101;
    do_reset();
    Test = 3'd5; auto_en = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      cpu_req = pat[i]; cpu_data = 32'h1000 + 32'(i);
      tick();
      checks++; if (in_hold !== 1'b1 || disp_sel !== 3'd0) begin
        errors++; $display("FAIL restart_hold_%0d got hold=%b sel=%0d want 1/0", i, in_hold, disp_sel); end
    end
    checks++; if (disp_num !== 32'h00001002) begin errors++; $display("FAIL restart_lastdata got %h want 00001002", disp_num); end
    cpu_req = 1'b0;
    tick();
    checks++; if (in_hold !== 1'b0 || disp_sel !== 3'd5 || disp_num !== 32'h55555555) begin
      errors++; $display("FAIL restart_resume got hold=%b sel=%0d disp=%h want 0/5/55555555", in_hold, disp_sel, disp_num); end
    cpu_req = 1'b1; cpu_data = 32'hCAFE0001;
    tick();
    checks++; if (in_hold !== 1'b1) begin errors++; $display("FAIL reenter_hold got %b want 1", in_hold); end
    auto_en = 1'b0; Test = 3'd2; cpu_data = 32'h0BADF00D;
    tick();
    checks++; if (in_hold !== 1'b0 || disp_sel !== 3'd2 || disp_num !== 32'h22222222 || cpu_ack !== 1'b1) begin
      errors++; $display("FAIL hold_abort got hold=%b sel=%0d disp=%h ack=%b want 0/2/22222222/1", in_hold, disp_sel, disp_num, cpu_ack); end
    cpu_req = 1'b0; Test = 3'd0;
    tick();
    checks++; if (disp_num !== 32'h0BADF00D || cpu_ack !== 1'b0) begin
      errors++; $display("FAIL hold_abort_latch got disp=%h ack=%b want 0badf00d/0", disp_num, cpu_ack); end
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    Test = 3'd1; auto_en = 1'b1; cpu_req = 1'b1; cpu_data = 32'h12121212;
    tick();
    checks++; if (in_hold !== 1'b1 || disp_num !== 32'h12121212) begin
      errors++; $display("FAIL midrst_enter got hold=%b disp=%h want 1/12121212", in_hold, disp_num); end
    cpu_req = 1'b0;
    tick();
    rst = 1'b1; cpu_req = 1'b1; cpu_data = 32'h99999999;
    tick();
    checks++; if (disp_num !== 32'hAA5555AA || in_hold !== 1'b0 || cpu_ack !== 1'b0 || disp_sel !== 3'd0) begin
      errors++; $display("FAIL midrst got disp=%h hold=%b ack=%b sel=%0d want aa5555aa/0/0/0", disp_num, in_hold, cpu_ack, disp_sel); end
    rst = 1'b0; cpu_req = 1'b0; auto_en = 1'b0; Test = 3'd0;
    tick();
    checks++; if (disp_num !== 32'hAA5555AA || cpu_ack !== 1'b0 || in_hold !== 1'b0) begin
      errors++; $display("FAIL midrst_after got disp=%h ack=%b hold=%b want aa5555aa/0/0", disp_num, cpu_ack, in_hold); end
  endtask

  task automatic test_min_params();
    logic [2:0] seq [3] = '{3'd2, 3'd3, 3'd4};
    do_reset();
    Test = 3'd2; auto_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (f_disp_sel !== seq[i]) begin errors++; $display("FAIL min_dwell_%0d got %0d want %0d", i, f_disp_sel, seq[i]); end
    end
    cpu_req = 1'b1; cpu_data = 32'h00000077;
    tick();
    checks++; if (f_in_hold !== 1'b1 || f_disp_sel !== 3'd0) begin
      errors++; $display("FAIL min_hold_enter got hold=%b sel=%0d want 1/0", f_in_hold, f_disp_sel); end
    cpu_req = 1'b0;
    tick();
    checks++; if (f_in_hold !== 1'b0 || f_disp_sel !== 3'd4) begin
      errors++; $display("FAIL min_hold_exit got hold=%b sel=%0d want 0/4", f_in_hold, f_disp_sel); end
    tick();
    checks++; if (f_disp_sel !== 3'd5) begin errors++; $display("FAIL min_after got %0d want 5", f_disp_sel); end
  endtask

  initial begin
    s1 = 32'h00400010; s2 = 32'h22222222; s3 = 32'h33333333; s4 = 32'h44444444;
    s5 = 32'h55555555; s6 = 32'h66666666; s7 = 32'h77777777;
    rst = 1'b1; auto_en = 1'b0; cpu_req = 1'b0; Test = 3'd0; cpu_data = 32'h0;
    test_reset();
    test_manual();
    test_back_to_back();
    test_auto_rotate();
    test_cpu_preempt();
    test_hold_restart();
    test_reset_mid_hold();
    test_min_params();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
